// File: rtl/mmio_arb_pkg.sv
// Shared types and constants for the two-master MMIO arbiter.
//   arb_state_t : arbiter FSM states
//   mmio_cmd_t  : command latched from the granted master (wr, lock, addr, wr_data)
package mmio_arb_pkg;

  localparam int unsigned MMIO_DATA_W = 32;
  localparam int unsigned MMIO_ADDR_W = 21;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    RESP
  } arb_state_t;

  typedef struct packed {
    logic                   wr;
    logic                   lock;
    logic [MMIO_ADDR_W-1:0] addr;
    logic [MMIO_DATA_W-1:0] wr_data;
  } mmio_cmd_t;

endpackage

// File: rtl/mmio_arbiter_if.sv
// Per-master req/ack handshake bundle for the MMIO arbiter.
//   req/wr/lock/addr/wr_data : master -> arbiter command, held until ack
//   ack                      : one-cycle completion pulse
//   rd_data                  : read data, valid with ack and held until the next ack
// Modports: master (the requester side), slave (the arbiter side).
interface mmio_arbiter_if #(
  parameter int unsigned ADDR_W = 21
);
  import mmio_arb_pkg::*;

  logic                   req;
  logic                   wr;
  logic                   lock;
  logic [ADDR_W-1:0]      addr;
  logic [MMIO_DATA_W-1:0] wr_data;
  logic                   ack;
  logic [MMIO_DATA_W-1:0] rd_data;

  modport master (
    output req, wr, lock, addr, wr_data,
    input  ack, rd_data
  );

  modport slave (
    input  req, wr, lock, addr, wr_data,
    output ack, rd_data
  );

endinterface

// File: rtl/rr_arb2.sv
// Combinational two-way round-robin pick.
//   req[1:0]    : request per master
//   last_grant  : index of the master served last (the other one wins a tie)
//   lock_active : a lock is held; only lock_owner may be granted
//   lock_owner  : index of the lock holder
//   gnt[1:0]    : one-hot grant, all-zero when nobody is granted
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  input  logic       lock_active,
  input  logic       lock_owner,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    if (lock_active) begin
      // The non-owner is ignored entirely while a lock is held.
      if (lock_owner) begin
        gnt = {req[1], 1'b0};
      end else begin
        gnt = {1'b0, req[0]};
      end
    end else begin
      unique case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = last_grant ? 2'b01 : 2'b10;
        default: gnt = 2'b00;
      endcase
    end
  end

endmodule

// File: rtl/mmio_arbiter.sv
// Two-master arbiter in front of the FPro MMIO controller.
//   clk, reset   : system clock, asynchronous active-low reset
//   m0, m1       : master handshake ports (m0 = CPU, m1 = UART debug/DMA bridge)
//   mmio_*       : single-cycle MMIO bus; strobes only during ISSUE
// Flow: IDLE picks a winner and latches its command, ISSUE drives the bus and
// captures read data, RESP pulses the winner's ack. A locked master keeps the
// grant for up to LOCK_MAX transactions or until it idles LOCK_IDLE cycles.
module mmio_arbiter
  import mmio_arb_pkg::*;
#(
  parameter int unsigned ADDR_W    = MMIO_ADDR_W,
  parameter int unsigned LOCK_MAX  = 8,
  parameter int unsigned LOCK_IDLE = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  mmio_arbiter_if.slave          m0,
  mmio_arbiter_if.slave          m1,
  output logic                   mmio_cs,
  output logic                   mmio_wr,
  output logic                   mmio_rd,
  output logic [ADDR_W-1:0]      mmio_addr,
  output logic [MMIO_DATA_W-1:0] mmio_wr_data,
  input  logic [MMIO_DATA_W-1:0] mmio_rd_data
);

  localparam int unsigned CntW  = $clog2(LOCK_MAX + 1);
  localparam int unsigned IdleW = $clog2(LOCK_IDLE + 1);

  arb_state_t                      state_q, state_d;
  mmio_cmd_t                       cmd_q, cmd_d;
  logic                            gnt_q, gnt_d;
  logic                            last_grant_q, last_grant_d;
  logic                            lock_active_q, lock_active_d;
  logic                            lock_owner_q, lock_owner_d;
  logic [CntW-1:0]                 lock_cnt_q, lock_cnt_d;
  logic [IdleW-1:0]                idle_cnt_q, idle_cnt_d;
  logic [1:0]                      ack_q, ack_d;
  logic [1:0][MMIO_DATA_W-1:0]     rd_data_q, rd_data_d;
  logic                            cs_q, cs_d, wr_q, wr_d, rd_q, rd_d;
  logic [ADDR_W-1:0]               addr_q, addr_d;
  logic [MMIO_DATA_W-1:0]          wdata_q, wdata_d;

  logic [1:0]                      arb_gnt;
  mmio_cmd_t                       cmd_m0, cmd_m1;

  assign cmd_m0 = '{wr: m0.wr, lock: m0.lock, addr: m0.addr, wr_data: m0.wr_data};
  assign cmd_m1 = '{wr: m1.wr, lock: m1.lock, addr: m1.addr, wr_data: m1.wr_data};

  rr_arb2 u_rr_arb2 (
    .req        ({m1.req, m0.req}),
    .last_grant (last_grant_q),
    .lock_active(lock_active_q),
    .lock_owner (lock_owner_q),
    .gnt        (arb_gnt)
  );

  always_comb begin
    state_d       = state_q;
    cmd_d         = cmd_q;
    gnt_d         = gnt_q;
    last_grant_d  = last_grant_q;
    lock_active_d = lock_active_q;
    lock_owner_d  = lock_owner_q;
    lock_cnt_d    = lock_cnt_q;
    idle_cnt_d    = idle_cnt_q;
    rd_data_d     = rd_data_q;
    ack_d         = 2'b00;
    cs_d          = 1'b0;
    wr_d          = 1'b0;
    rd_d          = 1'b0;
    addr_d        = '0;
    wdata_d       = '0;

    unique case (state_q)
      IDLE: begin
        if (|arb_gnt) begin
          gnt_d   = arb_gnt[1];
          cmd_d   = arb_gnt[1] ? cmd_m1 : cmd_m0;
          // Bus outputs are registered, so load them now to strobe during ISSUE.
          cs_d    = 1'b1;
          wr_d    = cmd_d.wr;
          rd_d    = ~cmd_d.wr;
          addr_d  = cmd_d.addr;
          wdata_d = cmd_d.wr_data;
          state_d = ISSUE;
        end else if (lock_active_q) begin
          // No grant while locked means the owner is not requesting.
          if (idle_cnt_q == IdleW'(LOCK_IDLE - 1)) begin
            lock_active_d = 1'b0;
            lock_cnt_d    = '0;
            idle_cnt_d    = '0;
          end else begin
            idle_cnt_d = idle_cnt_q + IdleW'(1);
          end
        end
      end
      ISSUE: begin
        if (!cmd_q.wr) begin
          rd_data_d[gnt_q] = mmio_rd_data;
        end
        ack_d[gnt_q] = 1'b1;
        state_d      = RESP;
      end
      RESP: begin
        last_grant_d = gnt_q;
        idle_cnt_d   = '0;
        // The transaction that brings the count to LOCK_MAX releases the lock.
        if (cmd_q.lock && (lock_cnt_q != CntW'(LOCK_MAX - 1))) begin
          lock_active_d = 1'b1;
          lock_owner_d  = gnt_q;
          lock_cnt_d    = lock_cnt_q + CntW'(1);
        end else begin
          lock_active_d = 1'b0;
          lock_cnt_d    = '0;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      cmd_q         <= '0;
      gnt_q         <= 1'b0;
      last_grant_q  <= 1'b1;
      lock_active_q <= 1'b0;
      lock_owner_q  <= 1'b0;
      lock_cnt_q    <= '0;
      idle_cnt_q    <= '0;
      rd_data_q     <= '0;
      ack_q         <= 2'b00;
      cs_q          <= 1'b0;
      wr_q          <= 1'b0;
      rd_q          <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
    end else begin
      state_q       <= state_d;
      cmd_q         <= cmd_d;
      gnt_q         <= gnt_d;
      last_grant_q  <= last_grant_d;
      lock_active_q <= lock_active_d;
      lock_owner_q  <= lock_owner_d;
      lock_cnt_q    <= lock_cnt_d;
      idle_cnt_q    <= idle_cnt_d;
      rd_data_q     <= rd_data_d;
      ack_q         <= ack_d;
      cs_q          <= cs_d;
      wr_q          <= wr_d;
      rd_q          <= rd_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
    end
  end

  assign mmio_cs      = cs_q;
  assign mmio_wr      = wr_q;
  assign mmio_rd      = rd_q;
  assign mmio_addr    = addr_q;
  assign mmio_wr_data = wdata_q;
  assign m0.ack       = ack_q[0];
  assign m0.rd_data   = rd_data_q[0];
  assign m1.ack       = ack_q[1];
  assign m1.rd_data   = rd_data_q[1];

endmodule

// File: tb/tb_mmio_arbiter.sv
// Self-checking bench for mmio_arbiter: reset state, a table of single
// transactions, directed arbitration/lock/reset sequences, then random traffic
// checked against a transaction-timeline reference model.
module tb_mmio_arbiter;
  import mmio_arb_pkg::*;

  localparam int unsigned AW         = 21;
  localparam int unsigned LockMax    = 8;
  localparam int unsigned LockIdle   = 16;
  localparam int          RandCycles = 3000;

  logic                   clk = 1'b0;
  logic                   reset;
  logic                   mmio_cs, mmio_wr, mmio_rd;
  logic [AW-1:0]          mmio_addr;
  logic [31:0]            mmio_wr_data, mmio_rd_data;

  mmio_arbiter_if #(.ADDR_W(AW)) m0_if ();
  mmio_arbiter_if #(.ADDR_W(AW)) m1_if ();

  mmio_arbiter #(
    .ADDR_W   (AW),
    .LOCK_MAX (LockMax),
    .LOCK_IDLE(LockIdle)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .m0          (m0_if),
    .m1          (m1_if),
    .mmio_cs     (mmio_cs),
    .mmio_wr     (mmio_wr),
    .mmio_rd     (mmio_rd),
    .mmio_addr   (mmio_addr),
    .mmio_wr_data(mmio_wr_data),
    .mmio_rd_data(mmio_rd_data)
  );

  always #5 clk = ~clk;

  // Slot model: combinational read data as a function of the bus address.
  function automatic logic [31:0] slot_val(input logic [AW-1:0] a);
    if (a == 21'h000041) return 32'hDEADBEEF;
    return {a[15:0], ~a[15:0]};
  endfunction

  assign mmio_rd_data = slot_val(mmio_addr);

  int n_pass = 0;
  int n_checks = 0;
  int cyc = 0;

  logic [AW-1:0] bus_addr_seen;
  logic [31:0]   bus_wd_seen;
  logic          bus_wr_seen;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic set_m(input int i, input logic req, input logic wr, input logic lock,
                       input logic [AW-1:0] addr, input logic [31:0] wd);
    if (i == 0) begin
      m0_if.req = req; m0_if.wr = wr; m0_if.lock = lock; m0_if.addr = addr;
      m0_if.wr_data = wd;
    end else begin
      m1_if.req = req; m1_if.wr = wr; m1_if.lock = lock; m1_if.addr = addr;
      m1_if.wr_data = wd;
    end
  endtask

  task automatic do_reset();
    set_m(0, 1'b0, 1'b0, 1'b0, '0, '0);
    set_m(1, 1'b0, 1'b0, 1'b0, '0, '0);
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  // Waits up to 'bound' cycles for an ack; who = -1 on timeout.
  task automatic next_ack(input int bound, output int who, output int dt);
    who = -1;
    dt = 0;
    bus_addr_seen = '0;
    bus_wd_seen = '0;
    bus_wr_seen = 1'b0;
    for (int k = 1; k <= bound && who < 0; k++) begin
      tick();
      if (mmio_cs) begin
        bus_addr_seen = mmio_addr;
        bus_wd_seen = mmio_wr_data;
        bus_wr_seen = mmio_wr;
      end
      if (m0_if.ack || m1_if.ack) begin
        who = m1_if.ack ? 1 : 0;
        dt = k;
      end
    end
  endtask

  typedef struct {
    int          who;
    logic        wr;
    logic [AW-1:0] addr;
    logic [31:0] wd;
    logic [31:0] exp_rd0;
    logic [31:0] exp_rd1;
  } vec_t;

  vec_t vecs[6];

  // Reference model state for the random phase.
  int          free_at, bus_cyc, ack_cyc, ack_who;
  logic        bus_w;
  logic [AW-1:0] bus_a;
  logic [31:0] bus_d;
  logic        exp_last;
  bit          lk_on;
  int          lk_own, lk_cnt, lk_idle;
  logic [31:0] exp_rd[2];
  logic        d_req[2], d_wr[2], d_lock[2];
  logic [AW-1:0] d_addr[2];
  logic [31:0] d_wd[2];
  int          rate[2], lk_bias[2];

  task automatic new_cmd(input int i);
    d_req[i] = 1'b1;
    d_wr[i] = 1'($urandom_range(0, 1));
    d_lock[i] = ($urandom_range(0, 3) < lk_bias[i]);
    d_addr[i] = AW'($urandom);
    d_wd[i] = $urandom;
  endtask

  initial begin
    int who, dt, win;
    logic acked, exp_cs;

    vecs[0] = '{0, 1'b0, 21'h000041, 32'h0,        32'hDEADBEEF, 32'h0};
    vecs[1] = '{1, 1'b0, 21'h001234, 32'h0,        32'hDEADBEEF, 32'h1234EDCB};
    vecs[2] = '{0, 1'b1, 21'h000055, 32'hCAFEF00D, 32'hDEADBEEF, 32'h1234EDCB};
    vecs[3] = '{1, 1'b1, 21'h1FFFFF, 32'hFFFFFFFF, 32'hDEADBEEF, 32'h1234EDCB};
    vecs[4] = '{0, 1'b0, 21'h00ABCD, 32'h0,        32'hABCD5432, 32'h1234EDCB};
    vecs[5] = '{1, 1'b0, 21'h100000, 32'h0,        32'hABCD5432, 32'h0000FFFF};

    // Reset state.
    set_m(0, 1'b0, 1'b0, 1'b0, '0, '0);
    set_m(1, 1'b0, 1'b0, 1'b0, '0, '0);
    reset = 1'b0;
    tick();
    tick();
    check("rst_cs", mmio_cs, 0);
    check("rst_wr", mmio_wr, 0);
    check("rst_rd", mmio_rd, 0);
    check("rst_addr", mmio_addr, 0);
    check("rst_wdata", mmio_wr_data, 0);
    check("rst_ack0", m0_if.ack, 0);
    check("rst_ack1", m1_if.ack, 0);
    check("rst_rd0", m0_if.rd_data, 0);
    check("rst_rd1", m1_if.rd_data, 0);
    reset = 1'b1;

    // Single transactions: strobe at t+1, ack at t+2, rd_data held afterwards.
    for (int v = 0; v < 6; v++) begin
      set_m(vecs[v].who, 1'b1, vecs[v].wr, 1'b0, vecs[v].addr, vecs[v].wd);
      tick();
      check("vec_cs", mmio_cs, 1);
      check("vec_wr", mmio_wr, vecs[v].wr);
      check("vec_rd", mmio_rd, !vecs[v].wr);
      check("vec_addr", mmio_addr, vecs[v].addr);
      check("vec_wdata", mmio_wr_data, vecs[v].wd);
      tick();
      check("vec_ack", vecs[v].who == 0 ? m0_if.ack : m1_if.ack, 1);
      check("vec_ack_other", vecs[v].who == 0 ? m1_if.ack : m0_if.ack, 0);
      check("vec_cs_off", mmio_cs, 0);
      check("vec_rd0", m0_if.rd_data, vecs[v].exp_rd0);
      check("vec_rd1", m1_if.rd_data, vecs[v].exp_rd1);
      set_m(vecs[v].who, 1'b0, 1'b0, 1'b0, '0, '0);
      tick();
      check("vec_ack_pulse", m0_if.ack | m1_if.ack, 0);
      check("vec_rd0_hold", m0_if.rd_data, vecs[v].exp_rd0);
    end

    // Simultaneous writes after reset: m0, m1, m0.
    do_reset();
    set_m(0, 1'b1, 1'b1, 1'b0, 21'h80, 32'h11);
    set_m(1, 1'b1, 1'b1, 1'b0, 21'h81, 32'h22);
    next_ack(10, who, dt);
    check("sim_first_who", who, 0);
    check("sim_first_lat", dt, 2);
    check("sim_first_addr", bus_addr_seen, 21'h80);
    check("sim_first_data", bus_wd_seen, 32'h11);
    check("sim_first_wr", bus_wr_seen, 1);
    next_ack(10, who, dt);
    check("sim_second_who", who, 1);
    check("sim_second_gap", dt, 3);
    check("sim_second_addr", bus_addr_seen, 21'h81);
    check("sim_second_data", bus_wd_seen, 32'h22);
    next_ack(10, who, dt);
    check("sim_third_who", who, 0);
    check("sim_third_gap", dt, 3);
    set_m(0, 1'b0, 1'b0, 1'b0, '0, '0);
    set_m(1, 1'b0, 1'b0, 1'b0, '0, '0);
    tick();

    // Locked read-modify-write by m1 while m0 keeps requesting.
    do_reset();
    set_m(1, 1'b1, 1'b0, 1'b1, 21'h40, 32'h0);
    tick();
    set_m(0, 1'b1, 1'b1, 1'b0, 21'h90, 32'h33);
    next_ack(10, who, dt);
    check("rmw_read_who", who, 1);
    check("rmw_read_lat", dt, 1);
    check("rmw_read_data", m1_if.rd_data, 32'h0040FFBF);
    set_m(1, 1'b1, 1'b1, 1'b0, 21'h40, 32'h55);
    next_ack(10, who, dt);
    check("rmw_write_who", who, 1);
    check("rmw_write_gap", dt, 3);
    check("rmw_write_addr", bus_addr_seen, 21'h40);
    check("rmw_write_wr", bus_wr_seen, 1);
    set_m(1, 1'b1, 1'b0, 1'b0, 21'h44, 32'h0);
    next_ack(10, who, dt);
    check("rmw_after_who", who, 0);
    set_m(0, 1'b0, 1'b0, 1'b0, '0, '0);
    next_ack(10, who, dt);
    check("rmw_then_m1", who, 1);
    set_m(1, 1'b0, 1'b0, 1'b0, '0, '0);
    tick();

    // Lock limit: m1 gets in right after m0's 8th locked ack.
    do_reset();
    set_m(0, 1'b1, 1'b0, 1'b1, 21'h10, 32'h0);
    set_m(1, 1'b1, 1'b0, 1'b0, 21'h20, 32'h0);
    for (int i = 0; i < 11; i++) begin
      next_ack(10, who, dt);
      check("lockmax_who", who, (i == 8) ? 1 : 0);
      if (i == 8) set_m(1, 1'b0, 1'b0, 1'b0, '0, '0);
    end
    check("lockmax_rd0", m0_if.rd_data, 32'h0010FFEF);
    set_m(0, 1'b0, 1'b0, 1'b0, '0, '0);
    tick();

    // Lock idle timeout: m1 served only after LOCK_IDLE idle cycles.
    do_reset();
    set_m(0, 1'b1, 1'b0, 1'b1, 21'h30, 32'h0);
    set_m(1, 1'b1, 1'b0, 1'b0, 21'h31, 32'h0);
    next_ack(10, who, dt);
    check("idle_owner_who", who, 0);
    set_m(0, 1'b0, 1'b0, 1'b0, '0, '0);
    next_ack(40, who, dt);
    check("idle_m1_who", who, 1);
    check("idle_m1_delay", dt, LockIdle + 3);
    set_m(1, 1'b0, 1'b0, 1'b0, '0, '0);
    tick();

    // Reset during ISSUE, then a tie goes to m0.
    do_reset();
    set_m(0, 1'b1, 1'b1, 1'b0, 21'h60, 32'h77);
    next_ack(10, who, dt);
    check("rstmid_pre_who", who, 0);
    set_m(0, 1'b0, 1'b0, 1'b0, '0, '0);
    set_m(1, 1'b1, 1'b0, 1'b0, 21'h61, 32'h0);
    for (int k = 0; k < 10 && !mmio_cs; k++) tick();
    check("rstmid_in_issue", mmio_cs, 1);
    reset = 1'b0;
    #1;
    check("rstmid_cs", mmio_cs, 0);
    check("rstmid_rd", mmio_rd, 0);
    check("rstmid_addr", mmio_addr, 0);
    check("rstmid_ack", m0_if.ack | m1_if.ack, 0);
    check("rstmid_rd0", m0_if.rd_data, 0);
    tick();
    check("rstmid_no_ack", m0_if.ack | m1_if.ack, 0);
    reset = 1'b1;
    set_m(0, 1'b1, 1'b0, 1'b0, 21'h62, 32'h0);
    next_ack(10, who, dt);
    check("rstmid_post_who", who, 0);
    check("rstmid_post_lat", dt, 2);
    set_m(0, 1'b0, 1'b0, 1'b0, '0, '0);
    set_m(1, 1'b0, 1'b0, 1'b0, '0, '0);
    tick();

    // Random traffic against the timeline model.
    do_reset();
    free_at = 0; bus_cyc = -10; ack_cyc = -10; ack_who = 0;
    bus_w = 1'b0; bus_a = '0; bus_d = '0;
    exp_last = 1'b1; lk_on = 0; lk_own = 0; lk_cnt = 0; lk_idle = 0;
    exp_rd[0] = '0; exp_rd[1] = '0;
    for (int i = 0; i < 2; i++) begin
      d_req[i] = 1'b0; d_wr[i] = 1'b0; d_lock[i] = 1'b0; d_addr[i] = '0; d_wd[i] = '0;
      rate[i] = 1; lk_bias[i] = 1;
    end
    for (int n = 0; n < RandCycles; n++) begin
      if (n == ack_cyc && !bus_w) exp_rd[ack_who] = slot_val(bus_a);
      exp_cs = (n == bus_cyc);
      check("rand_cs", mmio_cs, exp_cs);
      check("rand_wr", mmio_wr, exp_cs & bus_w);
      check("rand_rd", mmio_rd, exp_cs & ~bus_w);
      check("rand_addr", mmio_addr, exp_cs ? bus_a : '0);
      check("rand_wdata", mmio_wr_data, exp_cs ? bus_d : '0);
      check("rand_ack0", m0_if.ack, (n == ack_cyc) && (ack_who == 0));
      check("rand_ack1", m1_if.ack, (n == ack_cyc) && (ack_who == 1));
      check("rand_rd0", m0_if.rd_data, exp_rd[0]);
      check("rand_rd1", m1_if.rd_data, exp_rd[1]);

      if (n % 256 == 0) begin
        for (int i = 0; i < 2; i++) begin
          case ($urandom_range(0, 2))
            0: rate[i] = 0;
            1: rate[i] = 3;
            default: rate[i] = 40;
          endcase
          lk_bias[i] = $urandom_range(0, 3);
        end
      end

      // Masters: hold until ack, then re-request or go quiet.
      for (int i = 0; i < 2; i++) begin
        acked = (i == 0) ? m0_if.ack : m1_if.ack;
        if (d_req[i] && acked) begin
          if ($urandom_range(0, 1) == 1) new_cmd(i);
          else d_req[i] = 1'b0;
        end else if (!d_req[i] && ($urandom_range(0, rate[i]) == 0)) begin
          new_cmd(i);
        end
        set_m(i, d_req[i], d_wr[i], d_lock[i], d_addr[i], d_wd[i]);
      end

      // Arbitration happens only when the bus is free this cycle.
      if (n >= free_at) begin
        win = -1;
        if (lk_on) begin
          if (d_req[lk_own]) win = lk_own;
          else begin
            lk_idle++;
            if (lk_idle == LockIdle) begin lk_on = 0; lk_cnt = 0; lk_idle = 0; end
          end
        end else if (d_req[0] && d_req[1]) win = exp_last ? 0 : 1;
        else if (d_req[0]) win = 0;
        else if (d_req[1]) win = 1;
        if (win >= 0) begin
          bus_cyc = n + 1;
          ack_cyc = n + 2;
          free_at = n + 3;
          ack_who = win;
          bus_w = d_wr[win];
          bus_a = d_addr[win];
          bus_d = d_wd[win];
          exp_last = (win == 1);
          lk_idle = 0;
          if (d_lock[win]) begin
            lk_cnt++;
            if (lk_cnt == LockMax) begin lk_on = 0; lk_cnt = 0; end
            else begin lk_on = 1; lk_own = win; end
          end else begin
            lk_on = 0;
            lk_cnt = 0;
          end
        end
      end
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mmio_arbiter.md
Name: mmio_arbiter

Overview:
- Two-master arbiter placed in front of mmio_controller on the FPro MMIO bus.
- Lets master 0 (CPU) and master 1 (UART debug/DMA bridge) share the single-cycle MMIO bus.
- Each master uses a req/ack handshake. Grants alternate round-robin, and a bounded lock supports atomic read-modify-write.
- Read data is registered and returned with ack.

Parameters:
- ADDR_W, 21, MMIO word address width.
- LOCK_MAX, 8, maximum consecutive locked transactions before a forced release.
- LOCK_IDLE, 16, cycles a locked master may go without requesting before the lock is dropped.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- m0_req  in  1  master 0 request; held with its command until m0_ack.
- m0_wr  in  1  1 = write, 0 = read.
- m0_lock  in  1  keep grant after this transaction.
- m0_addr  in  ADDR_W  address.
- m0_wr_data  in  32  write data.
- m0_ack  out  1  one-cycle completion pulse.
- m0_rd_data  out  32  read data; valid with ack, held until the next m0 ack.
- m1_req / m1_wr / m1_lock / m1_addr / m1_wr_data / m1_ack / m1_rd_data: same as m0, for master 1.
- mmio_cs  out  1  bus chip select.
- mmio_wr  out  1  bus write strobe.
- mmio_rd  out  1  bus read strobe.
- mmio_addr  out  ADDR_W  bus address.
- mmio_wr_data  out  32  bus write data.
- mmio_rd_data  in  32  bus read data (combinational from slots).

Behaviour:
- Reset values: all outputs 0, state IDLE, last_grant = 1 (m0 wins the first tie), lock inactive, counters 0.
- FSM states and transitions:
  - IDLE: sample requests and pick a winner into gnt, then go to ISSUE. With no request, stay in IDLE.
  - ISSUE: drive the bus from the granted master's registered command. mmio_cs = 1; mmio_wr = cmd_wr; mmio_rd = ~cmd_wr. Capture mmio_rd_data into that master's rd_data register at the clock edge when the command is a read. Go to RESP.
  - RESP: pulse the granted master's ack for one cycle, update last_grant = gnt, go to IDLE.
- Bus outputs are registered and are 0 in every state except ISSUE.
- Latency: req seen in IDLE at cycle t → bus strobe at t+1 → ack at t+2. Maximum throughput is one transaction per 3 cycles.
- A req still high in the cycle after ack is a new request.
- Arbitration with no lock active:
  - Only one master requesting: that master is granted.
  - Both requesting: the master ≠ last_grant is granted.
- Lock:
  - If the granted command had lock = 1, the lock becomes active for that master at RESP. lock_cnt increments.
  - While the lock is active, IDLE grants only the lock owner; the other master's req is ignored.
  - The lock clears when any of these occurs:
    - The owner completes a transaction with lock = 0.
    - lock_cnt reaches LOCK_MAX; that transaction completes normally and the next arbitration is round-robin.
    - The owner's req stays low for LOCK_IDLE consecutive IDLE cycles.
  - When the lock clears, lock_cnt and the idle counter reset to 0.
- The command (wr, addr, wr_data, lock) is latched on the IDLE→ISSUE transition. Master changes after that point are ignored until ack.
- Reset asserted mid-transaction: the transaction is abandoned, no ack is issued, and all outputs return to reset values immediately (asynchronously).
- rd_data of the non-granted master is never modified. A write transaction does not modify rd_data.

Decomposition:
- Shared package mmio_arb_pkg:
  - typedef enum {IDLE, ISSUE, RESP} arb_state_t.
  - struct mmio_cmd_t {wr, lock, addr, wr_data}.
  - Constant MMIO_DATA_W = 32.
- One sub-module, rr_arb2: combinational 2-way round-robin pick with inputs req[1:0], last_grant, lock_active, lock_owner and output gnt.
- FSM, counters and registers live in the top-level module.

Test Plan:
- Single read: m0 reads addr 0x000041 with the slot returning 0xDEADBEEF. Required: mmio_rd = 1 at t+1; m0_ack at t+2; m0_rd_data = 0xDEADBEEF held afterwards; m1_ack stays 0.
- Simultaneous requests after reset: m0 and m1 both write, m0 0x11 to 0x80, m1 0x22 to 0x81. Required: bus order is m0 then m1; acks 3 cycles apart. A third simultaneous pair is granted to m0 again (alternation).
- Locked RMW: m1 does read 0x40 with lock = 1, then write 0x40 with lock = 0, while m0_req stays high throughout. Required: both m1 transactions are served consecutively; m0 is granted next.
- Lock limit: m0 issues 10 back-to-back locked reads with m1 requesting. Required: m1 is granted after m0's 8th ack (LOCK_MAX = 8).
- Lock idle timeout: m0 takes the lock, then drops req for 16 IDLE cycles while m1 requests. Required: m1 is granted after the timeout, not before.
- Reset mid-transaction: reset pulsed low during ISSUE. Required: mmio_cs = 0 and ack = 0 immediately; after release, the first simultaneous request goes to m0.
